// File: rtl/ws2812_pkg.sv
// Shared WS2812 types and default 50 MHz timing, also used by the 100 MHz variant and cal_block.
package ws2812_pkg;

  typedef logic [23:0] grb_t;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    LATCH
  } tx_state_t;

  localparam int unsigned T0H_CYC_50M = 20;
  localparam int unsigned T1H_CYC_50M = 40;
  localparam int unsigned BIT_CYC_50M = 63;
  localparam int unsigned RST_CYC_50M = 15000;

endpackage

// File: rtl/ws2812_bit_timer.sv
// Times one WS2812 bit: a high phase of T0H/T1H cycles, then low up to BIT_CYC.
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H_CYC = T0H_CYC_50M,
  parameter int unsigned T1H_CYC = T1H_CYC_50M,
  parameter int unsigned BIT_CYC = BIT_CYC_50M
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic bit_val,
  output logic high,
  output logic high_end,
  output logic bit_end
);

  localparam int unsigned CNT_W = $clog2(BIT_CYC);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] th;
  logic [CNT_W-1:0] th_last;
  logic             active;
  logic             val_q;

  assign th       = val_q ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
  assign th_last  = val_q ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
  assign high     = active && (cnt < th);
  assign high_end = active && (cnt == th_last);
  assign bit_end  = active && (cnt == CNT_W'(BIT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      val_q  <= 1'b0;
    end else if (go) begin
      active <= 1'b1;
      cnt    <= '0;
      val_q  <= bit_val;
    end else if (bit_end) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ws2812_frame_tx.sv
// WS2812 frame serializer: snapshots the GRB array on start, emits LED 0 first, MSB first,
// then holds the line low for the latch time and pulses done.
module ws2812_frame_tx
  import ws2812_pkg::*;
#(
  parameter int unsigned LED_NUM = 32,
  parameter int unsigned T0H_CYC = T0H_CYC_50M,
  parameter int unsigned T1H_CYC = T1H_CYC_50M,
  parameter int unsigned BIT_CYC = BIT_CYC_50M,
  parameter int unsigned RST_CYC = RST_CYC_50M
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  grb_t data [LED_NUM],
  output logic signal,
  output logic busy,
  output logic done
);

  localparam int unsigned MAX_CYC = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
  localparam int unsigned CYC_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned LED_W   = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

  if (LED_NUM < 1 || T0H_CYC < 1 || T0H_CYC >= T1H_CYC || T1H_CYC >= BIT_CYC || RST_CYC < 1)
  begin : g_param_check
    $error("ws2812_frame_tx: invalid LED_NUM or timing parameters");
  end

  tx_state_t        state, state_nxt;
  logic [CYC_W-1:0] cyc;
  logic [4:0]       bit_idx, bit_nxt;
  logic [LED_W-1:0] led_idx, led_nxt;
  grb_t             snap [LED_NUM];

  logic go, bit_val, tmr_high, high_end, bit_end, latch_end, accept;

  ws2812_bit_timer #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .bit_val  (bit_val),
    .high     (tmr_high),
    .high_end (high_end),
    .bit_end  (bit_end)
  );

  // done is still showing in IDLE's first cycle; a start seen then is dropped
  assign accept    = (state == IDLE) && start && !done;
  assign latch_end = (state == LATCH) && (cyc == CYC_W'(RST_CYC));

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_idx;
    led_nxt   = led_idx;
    go        = 1'b0;
    bit_val   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = HIGH;
          bit_nxt   = 5'd23;
          led_nxt   = '0;
          go        = 1'b1;
          bit_val   = data[0][23];
        end
      end
      HIGH: begin
        if (high_end) state_nxt = LOW;
      end
      LOW: begin
        if (bit_end) begin
          if (bit_idx != 5'd0) begin
            bit_nxt   = bit_idx - 5'd1;
            state_nxt = HIGH;
            go        = 1'b1;
            bit_val   = snap[led_idx][bit_nxt];
          end else if (led_idx != LED_W'(LED_NUM - 1)) begin
            led_nxt   = led_idx + LED_W'(1);
            bit_nxt   = 5'd23;
            state_nxt = HIGH;
            go        = 1'b1;
            bit_val   = snap[led_nxt][23];
          end else begin
            state_nxt = LATCH;
          end
        end
      end
      LATCH: begin
        if (latch_end) state_nxt = IDLE;
      end
    endcase
  end

  // Outputs trail the state by one register stage; reset forces them directly, so the
  // post-reset latch count starts at 1 to give the same RST_CYC low cycles before done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LATCH;
      cyc     <= CYC_W'(1);
      bit_idx <= '0;
      led_idx <= '0;
      signal  <= 1'b0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_nxt;
      led_idx <= led_nxt;
      if (state == LATCH && !latch_end) cyc <= cyc + CYC_W'(1);
      else                              cyc <= '0;
      signal  <= tmr_high;
      busy    <= (state != IDLE) && !latch_end;
      done    <= latch_end;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int unsigned i = 0; i < LED_NUM; i++) snap[i] <= data[i];
    end
  end

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Self-checking bench for ws2812_frame_tx: every output cycle of each frame is compared
// against a waveform computed arithmetically from the captured GRB words.
module tb_ws2812_frame_tx;
  import ws2812_pkg::*;

  localparam int unsigned LED_NUM = 2;
  localparam int unsigned T0H     = 2;
  localparam int unsigned T1H     = 4;
  localparam int unsigned BITC    = 6;
  localparam int unsigned RSTC    = 10;
  localparam int BITS   = LED_NUM * 24 * BITC;  // 288 bit cycles per frame
  localparam int FRAME  = BITS + RSTC;          // first rise to done
  localparam int RST_AT = 30 * BITC;            // first cycle of bit 30

  logic clk = 1'b0;
  logic rst, start;
  logic signal, busy, done;
  grb_t data  [LED_NUM];
  grb_t ref_w [LED_NUM];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned ncyc    = 0;
  int unsigned acc_a, acc_b;

  always #5 clk = ~clk;

  ws2812_frame_tx #(
    .LED_NUM (LED_NUM),
    .T0H_CYC (T0H),
    .T1H_CYC (T1H),
    .BIT_CYC (BITC),
    .RST_CYC (RSTC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data   (data),
    .signal (signal),
    .busy   (busy),
    .done   (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference waveform: cycle t after the first rise, from the captured words.
  function automatic logic exp_sig(input int t);
    int  led, bitn, ph;
    logic b;
    if (t >= BITS) return 1'b0;
    led  = t / (24 * BITC);
    bitn = 23 - (t / BITC) % 24;
    ph   = t % BITC;
    b    = ref_w[led][bitn];
    return ph < (b ? T1H : T0H);
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < LED_NUM; i++) data[i] = 24'($urandom);
  endtask

  task automatic check_outs(input string tag, input logic s, input logic b, input logic d);
    check({tag, " signal"}, signal, s);
    check({tag, " busy"}, busy, b);
    check({tag, " done"}, done, d);
  endtask

  // Entered #1 after the edge that accepted start. mode 1: random start pulses while busy;
  // mode 2: reset at bit 30; mode 3: start held high (left as is).
  task automatic frame_body(input int mode);
    check_outs("entry", 1'b0, 1'b0, 1'b0);
    for (int t = 0; t <= FRAME; t++) begin
      if (mode == 1) start = ($urandom_range(0, 3) == 0);
      tick();
      check_outs($sformatf("frame t=%0d", t), exp_sig(t), t < FRAME, t == FRAME);
      if (mode == 2 && t == RST_AT) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("after rst", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < int'(RSTC); i++) begin
          tick();
          check_outs($sformatf("rst latch %0d", i), 1'b0, 1'b1, 1'b0);
        end
        tick();
        check_outs("rst latch done", 1'b0, 1'b0, 1'b1);
        return;
      end
    end
    if (mode == 1) start = 1'b0;
  endtask

  // Called in the done cycle: start there must be dropped, start on the next cycle taken.
  task automatic chain_start();
    start = 1'b1;
    tick();
    check_outs("done-cycle start", 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("post-done accept", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_start();
    tick();
    check_outs("idle", 1'b0, 1'b0, 1'b0);
    ref_w = data;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    randomize_data();

    // Reset with start held: latch, done, then back-to-back frames.
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 1; i < int'(RSTC); i++) begin
      tick();
      check_outs($sformatf("reset latch %0d", i), 1'b0, 1'b1, 1'b0);
    end
    tick();
    check_outs("reset latch done", 1'b0, 1'b0, 1'b1);
    ref_w = data;
    chain_start();
    acc_a = ncyc;
    frame_body(3);
    randomize_data();
    ref_w = data;
    chain_start();
    acc_b = ncyc;
    check_int("held-start spacing", int'(acc_b - acc_a), FRAME + 3);
    frame_body(3);
    start = 1'b0;
    tick();
    tick();
    check_outs("idle after held", 1'b0, 1'b0, 1'b0);

    // Directed words: MSB-heavy LED 0, LSB-only LED 1.
    data[0] = 24'hFF0000;
    data[1] = 24'h000001;
    pulse_start();
    frame_body(0);

    // All-zero frame.
    data[0] = 24'h000000;
    data[1] = 24'h000000;
    pulse_start();
    frame_body(0);

    // Snapshot isolation and ignored starts while busy.
    randomize_data();
    pulse_start();
    for (int i = 0; i < LED_NUM; i++) data[i] = 24'hFFFFFF;
    frame_body(1);
    ref_w = data;
    chain_start();
    start = 1'b0;
    frame_body(0);

    // Mid-frame reset, then a complete frame.
    randomize_data();
    pulse_start();
    frame_body(2);
    randomize_data();
    pulse_start();
    frame_body(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
